// File: rtl/ips_bram_arb_if.sv
// Request/response and BRAM port-A bundle for the two-client BRAM arbiter.
// The arbiter uses the slave view; clients and the BRAM model use the master view.
interface ips_bram_arb_if #(
  parameter int WD_BRAM_ADR = 8,
  parameter int WD_BRAM_DAT = 32
);
  logic                   s_req0_valid;
  logic                   s_req0_ready;
  logic                   s_req0_we;
  logic [WD_BRAM_ADR-1:0] s_req0_addr;
  logic [WD_BRAM_DAT-1:0] s_req0_wdat;
  logic                   s_req1_valid;
  logic                   s_req1_ready;
  logic                   s_req1_we;
  logic [WD_BRAM_ADR-1:0] s_req1_addr;
  logic [WD_BRAM_DAT-1:0] s_req1_wdat;
  logic                   m_rsp0_valid;
  logic [WD_BRAM_DAT-1:0] m_rsp0_data;
  logic                   m_rsp1_valid;
  logic [WD_BRAM_DAT-1:0] m_rsp1_data;
  logic                   m_bram_ena;
  logic                   m_bram_wea;
  logic [WD_BRAM_ADR-1:0] m_bram_addra;
  logic [WD_BRAM_DAT-1:0] m_bram_dina;
  logic [WD_BRAM_DAT-1:0] m_bram_douta;

  modport slave (
    input  s_req0_valid, s_req0_we, s_req0_addr, s_req0_wdat,
    input  s_req1_valid, s_req1_we, s_req1_addr, s_req1_wdat,
    output s_req0_ready, s_req1_ready,
    output m_rsp0_valid, m_rsp0_data, m_rsp1_valid, m_rsp1_data,
    output m_bram_ena, m_bram_wea, m_bram_addra, m_bram_dina,
    input  m_bram_douta
  );

  modport master (
    output s_req0_valid, s_req0_we, s_req0_addr, s_req0_wdat,
    output s_req1_valid, s_req1_we, s_req1_addr, s_req1_wdat,
    input  s_req0_ready, s_req1_ready,
    input  m_rsp0_valid, m_rsp0_data, m_rsp1_valid, m_rsp1_data,
    input  m_bram_ena, m_bram_wea, m_bram_addra, m_bram_dina,
    output m_bram_douta
  );
endinterface

// File: rtl/ips_bram_arb.sv
// Round-robin arbiter sharing BRAM port A between two clients; reads are tagged
// through the fixed BRAM latency and returned in issue order to their owner.
module ips_bram_arb #(
  parameter int NB_BRAM_DLY = 2,
  parameter int WD_BRAM_ADR = 8,
  parameter int WD_BRAM_DAT = 32,
  parameter int WD_CNT      = 16
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_resetn,
  ips_bram_arb_if.slave     bus,
  output logic [WD_CNT-1:0] o_conflict_cnt
);

  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} req_id_e;

  // Tag stages: one per BRAM latency clock plus the stage that lines up with douta.
  localparam int NB_TAG = NB_BRAM_DLY + 1;

  req_id_e                rr_q;
  logic                   gnt0, gnt1, acc;
  logic                   sel_we;
  logic [WD_BRAM_ADR-1:0] sel_addr;
  logic [WD_BRAM_DAT-1:0] sel_wdat;

  logic                   ena_p0, wea_p0;
  logic [WD_BRAM_ADR-1:0] addra_p0;
  logic [WD_BRAM_DAT-1:0] dina_p0;

  logic                   rd_vld_p [NB_TAG];
  req_id_e                rd_id_p  [NB_TAG];
  logic                   rsp_hit0, rsp_hit1;

  logic                   rsp0_vld_p, rsp1_vld_p;
  logic [WD_BRAM_DAT-1:0] rsp0_dat_p, rsp1_dat_p;
  logic [WD_CNT-1:0]      cnt_q;

  function automatic logic [WD_CNT-1:0] sat_inc(input logic [WD_CNT-1:0] v);
    return (&v) ? v : v + {{(WD_CNT-1){1'b0}}, 1'b1};
  endfunction

  // Grant is gated by reset so ready reads 0 while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (i_sys_resetn) begin
      if (bus.s_req0_valid && (!bus.s_req1_valid || rr_q == REQ0)) gnt0 = 1'b1;
      else if (bus.s_req1_valid)                                   gnt1 = 1'b1;
    end
  end

  assign acc      = gnt0 | gnt1;
  assign sel_we   = gnt1 ? bus.s_req1_we   : bus.s_req0_we;
  assign sel_addr = gnt1 ? bus.s_req1_addr : bus.s_req0_addr;
  assign sel_wdat = gnt1 ? bus.s_req1_wdat : bus.s_req0_wdat;

  assign rsp_hit0 = rd_vld_p[NB_TAG-1] && (rd_id_p[NB_TAG-1] == REQ0);
  assign rsp_hit1 = rd_vld_p[NB_TAG-1] && (rd_id_p[NB_TAG-1] == REQ1);

  // p0: accepted request onto the BRAM port, tag stage 0, priority pointer
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      rr_q     <= REQ0;
      ena_p0   <= 1'b0;
      wea_p0   <= 1'b0;
      addra_p0 <= '0;
      dina_p0  <= '0;
      cnt_q    <= '0;
    end else begin
      ena_p0 <= acc;
      wea_p0 <= acc & sel_we;
      if (acc) begin
        rr_q     <= gnt0 ? REQ1 : REQ0;
        addra_p0 <= sel_addr;
        dina_p0  <= sel_wdat;
      end
      if (bus.s_req0_valid && bus.s_req1_valid) cnt_q <= sat_inc(cnt_q);
    end
  end

  // p1..pN: read tags ride alongside the BRAM latency; in-flight tags die on reset
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      for (int i = 0; i < NB_TAG; i++) begin
        rd_vld_p[i] <= 1'b0;
        rd_id_p[i]  <= REQ0;
      end
    end else begin
      rd_vld_p[0] <= acc & ~sel_we;
      rd_id_p[0]  <= gnt1 ? REQ1 : REQ0;
      for (int i = 1; i < NB_TAG; i++) begin
        rd_vld_p[i] <= rd_vld_p[i-1];
        rd_id_p[i]  <= rd_id_p[i-1];
      end
    end
  end

  // Response stage: capture douta for the tagged owner; the other side holds
  always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
    if (!i_sys_resetn) begin
      rsp0_vld_p <= 1'b0;
      rsp1_vld_p <= 1'b0;
      rsp0_dat_p <= '0;
      rsp1_dat_p <= '0;
    end else begin
      rsp0_vld_p <= rsp_hit0;
      rsp1_vld_p <= rsp_hit1;
      if (rsp_hit0) rsp0_dat_p <= bus.m_bram_douta;
      if (rsp_hit1) rsp1_dat_p <= bus.m_bram_douta;
    end
  end

  assign bus.s_req0_ready = gnt0;
  assign bus.s_req1_ready = gnt1;
  assign bus.m_bram_ena   = ena_p0;
  assign bus.m_bram_wea   = wea_p0;
  assign bus.m_bram_addra = addra_p0;
  assign bus.m_bram_dina  = dina_p0;
  assign bus.m_rsp0_valid = rsp0_vld_p;
  assign bus.m_rsp0_data  = rsp0_dat_p;
  assign bus.m_rsp1_valid = rsp1_vld_p;
  assign bus.m_rsp1_data  = rsp1_dat_p;
  assign o_conflict_cnt   = cnt_q;

endmodule

// File: tb/tb_ips_bram_arb.sv
// Scoreboard bench for ips_bram_arb: directed requests push expected read data
// and arrival cycle; a negedge monitor pops and compares every response.
module tb_ips_bram_arb;
  localparam int NB_BRAM_DLY = 2;
  localparam int WD_ADR = 8;
  localparam int WD_DAT = 32;
  localparam int WD_CNT = 4;

  typedef struct {
    logic [WD_DAT-1:0] d;
    int                cyc;
  } rsp_t;

  logic              clk;
  logic              rstn;
  logic [WD_CNT-1:0] cnt;
  int                cyc;
  int                checks;
  int                failures;
  rsp_t              q0[$];
  rsp_t              q1[$];
  logic [WD_DAT-1:0] last0, last1;
  logic [WD_DAT-1:0] mem [256];
  logic [WD_DAT-1:0] rd_p1;

  ips_bram_arb_if #(.WD_BRAM_ADR(WD_ADR), .WD_BRAM_DAT(WD_DAT)) bif ();

  ips_bram_arb #(
    .NB_BRAM_DLY(NB_BRAM_DLY),
    .WD_BRAM_ADR(WD_ADR),
    .WD_BRAM_DAT(WD_DAT),
    .WD_CNT     (WD_CNT)
  ) dut (
    .i_sys_clk     (clk),
    .i_sys_resetn  (rstn),
    .bus           (bif.slave),
    .o_conflict_cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model, two-clock read latency; contents are 0x5A00_0000 + address after reset
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5A00_0000 + i;
    end else if (bif.m_bram_ena) begin
      if (bif.m_bram_wea) mem[bif.m_bram_addra] <= bif.m_bram_dina;
      else                rd_p1 <= mem[bif.m_bram_addra];
    end
    bif.m_bram_douta <= rd_p1;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Response monitor
  always @(negedge clk) begin
    rsp_t e;
    if (bif.m_rsp0_valid) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp0_unexpected actual=1 required=0 data=0x%0h (t=%0t)", bif.m_rsp0_data, $time);
      end else begin
        e = q0.pop_front();
        chk("rsp0_data", bif.m_rsp0_data, e.d);
        chk("rsp0_cycle", cyc, e.cyc);
        last0 = e.d;
      end
    end else chk("rsp0_hold", bif.m_rsp0_data, last0);
    if (bif.m_rsp1_valid) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL rsp1_unexpected actual=1 required=0 data=0x%0h (t=%0t)", bif.m_rsp1_data, $time);
      end else begin
        e = q1.pop_front();
        chk("rsp1_data", bif.m_rsp1_data, e.d);
        chk("rsp1_cycle", cyc, e.cyc);
        last1 = e.d;
      end
    end else chk("rsp1_hold", bif.m_rsp1_data, last1);
  end

  task automatic set_req(input bit id, input bit v, input bit we,
                         input logic [WD_ADR-1:0] a, input logic [WD_DAT-1:0] w);
    if (id == 1'b0) begin
      bif.s_req0_valid = v; bif.s_req0_we = we; bif.s_req0_addr = a; bif.s_req0_wdat = w;
    end else begin
      bif.s_req1_valid = v; bif.s_req1_we = we; bif.s_req1_addr = a; bif.s_req1_wdat = w;
    end
  endtask

  task automatic push_exp(input bit id, input logic [WD_DAT-1:0] d, input int hs);
    rsp_t e;
    e.d   = d;
    e.cyc = hs + NB_BRAM_DLY + 1;
    if (id == 1'b0) q0.push_back(e);
    else            q1.push_back(e);
  endtask

  // Called just after a posedge; returns after the handshake edge (+1).
  task automatic issue(input bit id, input bit we, input logic [WD_ADR-1:0] a,
                       input logic [WD_DAT-1:0] w, input logic [WD_DAT-1:0] exp_d,
                       input int gap, output int hs);
    logic rdy;
    int   n;
    hs  = -1;
    rdy = 1'b0;
    n   = 0;
    repeat (gap) begin @(posedge clk); #1; end
    set_req(id, 1'b1, we, a, w);
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = (id == 1'b0) ? bif.s_req0_ready : bif.s_req1_ready;
      n++;
    end
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL issue_timeout id=%0d actual=no_ready required=ready", id);
      set_req(id, 1'b0, we, a, w);
      return;
    end
    @(posedge clk); #1;
    hs = cyc;
    set_req(id, 1'b0, we, a, w);
    if (!we) push_exp(id, exp_d, hs);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 30) begin
      @(posedge clk); #1; n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    rstn  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int h0, h1, h2, hd;
    logic [WD_ADR-1:0] a0, a1;
    checks = 0; failures = 0; cyc = 0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    do_reset();

    // Reset state with both requests presented
    repeat (3) @(posedge clk);
    #1;
    set_req(1'b0, 1'b1, 1'b0, 8'h01, '0);
    set_req(1'b1, 1'b1, 1'b0, 8'h02, '0);
    #1;
    chk("rst_ready0", bif.s_req0_ready, 0);
    chk("rst_ready1", bif.s_req1_ready, 0);
    chk("rst_bram", {bif.m_bram_ena, bif.m_bram_wea, bif.m_bram_addra, bif.m_bram_dina}, 0);
    chk("rst_cnt", cnt, 0);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Single client write then read of 0x10
    issue(1'b0, 1'b1, 8'h10, 32'hA5A5_0001, '0, 0, hd);
    chk("wr_bram_port", {bif.m_bram_ena, bif.m_bram_wea, bif.m_bram_addra, bif.m_bram_dina},
        {1'b1, 1'b1, 8'h10, 32'hA5A5_0001});
    issue(1'b0, 1'b0, 8'h10, '0, 32'hA5A5_0001, 0, hd);
    chk("rd_bram_port", {bif.m_bram_ena, bif.m_bram_wea, bif.m_bram_addra}, {1'b1, 1'b0, 8'h10});
    @(posedge clk); #1;
    chk("idle_bram_port", {bif.m_bram_ena, bif.m_bram_wea, bif.m_bram_addra}, {1'b0, 1'b0, 8'h10});
    drain();

    // Reads at relative cycles 0,1,4
    issue(1'b0, 1'b0, 8'h30, '0, 32'h5A00_0030, 0, h0);
    issue(1'b0, 1'b0, 8'h31, '0, 32'h5A00_0031, 0, h1);
    issue(1'b0, 1'b0, 8'h32, '0, 32'h5A00_0032, 2, h2);
    chk("gap_hs1", h1 - h0, 1);
    chk("gap_hs2", h2 - h0, 4);
    drain();

    // req1 writes 0x20, req0 reads it in the following slot
    fork
      issue(1'b1, 1'b1, 8'h20, 32'h0000_1234, '0, 0, hd);
      begin
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 8'h20, '0, 32'h0000_1234, 0, h0);
      end
    join
    drain();
    chk("cnt_no_contention", cnt, 0);

    // Reset in the middle of a req0 read burst (leaves rr pointing at req1)
    set_req(1'b0, 1'b1, 1'b0, 8'h40, '0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      bif.s_req0_addr = 8'h40 + 8'(i);
    end
    #3;
    set_req(1'b0, 1'b1, 1'b0, 8'h00, '0);
    set_req(1'b1, 1'b1, 1'b0, 8'h80, '0);
    do_reset();
    #1;
    chk("mid_rst_ready", {bif.s_req1_ready, bif.s_req0_ready}, 0);
    chk("mid_rst_bram", {bif.m_bram_ena, bif.m_bram_wea, bif.m_bram_addra, bif.m_bram_dina}, 0);
    chk("mid_rst_rsp", {bif.m_rsp1_valid, bif.m_rsp0_valid, bif.m_rsp1_data, bif.m_rsp0_data}, 0);
    chk("mid_rst_cnt", cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    #1;

    // Eight cycles of dual read contention: grants 0,1,0,1,...
    a0 = 8'h00;
    a1 = 8'h80;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("contend_gnt%0d", i), {bif.s_req1_ready, bif.s_req0_ready},
          (i % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      if (i % 2 == 0) begin
        push_exp(1'b0, 32'h5A00_0000 + {24'h0, a0}, cyc);
        a0 = a0 + 8'h01;
        bif.s_req0_addr = a0;
      end else begin
        push_exp(1'b1, 32'h5A00_0000 + {24'h0, a1}, cyc);
        a1 = a1 + 8'h01;
        bif.s_req1_addr = a1;
      end
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    chk("cnt_after_contention", cnt, 8);
    drain();

    // Write contention until the 4-bit counter saturates
    set_req(1'b0, 1'b1, 1'b1, 8'hF0, 32'h1111_0000);
    set_req(1'b1, 1'b1, 1'b1, 8'hF1, 32'h2222_0000);
    repeat (6) @(posedge clk);
    #1;
    chk("cnt_14", cnt, 14);
    repeat (14) @(posedge clk);
    #1;
    chk("cnt_sat_20", cnt, 15);
    repeat (5) @(posedge clk);
    #1;
    chk("cnt_sat_hold", cnt, 15);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ips_bram_arb.md
# ips_bram_arb

Two-requester round-robin arbiter that shares one port of the `ips_bram` simulation/implementation BRAM (port A) between two independent clients in the imaging pipeline, e.g. a line-buffer writer and a window reader. It accepts read/write requests through valid/ready handshakes and issues at most one registered BRAM access per cycle. It tracks in-flight reads through the fixed BRAM read latency and returns read data to the requester that issued the read, in order.

## Interface
Parameters:
- NB_BRAM_DLY, 2, BRAM read latency in clocks (edge sampling ena to data on dout); must match the attached BRAM, ≥1
- WD_BRAM_ADR, 8, address width
- WD_BRAM_DAT, 32, data width
- WD_CNT, 16, width of conflict counter

Ports:
- i_sys_clk  in  1  single clock for all logic
- i_sys_resetn  in  1  reset, asynchronous, active-low
- s_req0_valid / s_req1_valid  in  1  request present
- s_req0_ready / s_req1_ready  out  1  request accepted this cycle (grant)
- s_req0_we / s_req1_we  in  1  1 = write, 0 = read
- s_req0_addr / s_req1_addr  in  WD_BRAM_ADR  address
- s_req0_wdat / s_req1_wdat  in  WD_BRAM_DAT  write data
- m_rsp0_valid / m_rsp1_valid  out  1  read data valid, one-cycle pulse, no backpressure
- m_rsp0_data / m_rsp1_data  out  WD_BRAM_DAT  read data
- m_bram_ena  out  1  BRAM enable
- m_bram_wea  out  1  BRAM write enable
- m_bram_addra  out  WD_BRAM_ADR  BRAM address
- m_bram_dina  out  WD_BRAM_DAT  BRAM write data
- m_bram_douta  in  WD_BRAM_DAT  BRAM read data
- o_conflict_cnt  out  WD_CNT  cycles with both requests valid, saturating

## Operation
- Grant combinational: only one valid → that requester granted; both valid → requester pointed to by priority pointer `rr` granted. s_reqN_ready = grant to N. Neither valid → no grant.
- `rr` updates only on an accepted request: `rr` ← the non-granted requester. Reset value: `rr` = 0.
- Accepted request registered onto BRAM port: m_bram_ena=1, wea=we, addra=addr, dina=wdat for exactly one cycle. In cycles without acceptance, ena=0, wea=0, addra/dina hold their previous value.
- Read tag pipeline, NB_BRAM_DLY+1 stages of {valid, id}: a stage-0 entry is loaded for every accepted read and shifts every cycle. At the last stage, m_bram_douta is registered into m_rspN_data of the tagged id and m_rspN_valid pulses. The other requester's data holds and its valid stays 0.
- Writes produce no response.
- Ordering: strictly in issue order. A read accepted after a write to the same address returns the new data. No hazard logic is needed because the port is single and in-order.
- o_conflict_cnt increments in every cycle with s_req0_valid & s_req1_valid. It saturates at all-ones.
- Requesters must hold valid/we/addr/wdat stable until ready. Dropping valid before ready is permitted; the request is then simply not issued.

## Timing
- Handshake at edge T (valid & ready high in the preceding cycle) → m_bram_ena high in cycle T..T+1.
- BRAM samples at edge T+1. Data is on m_bram_douta after edge T+NB_BRAM_DLY. It is captured at edge T+NB_BRAM_DLY+1.
- Read latency, handshake edge → m_rspN_valid high: NB_BRAM_DLY+1 cycles after edge T. Default: rsp valid in cycle following edge T+3.
- Throughput: one access per cycle sustained. Under continuous dual contention, grants alternate 0,1,0,1…
- Reset (async assert, sync-safe deassert):
  - s_reqN_ready=0, m_bram_ena=0, wea=0, addra=0, dina=0.
  - m_rspN_valid=0, m_rspN_data=0.
  - o_conflict_cnt=0, `rr`=0, all tag stages invalid.
- Reset mid-operation: in-flight reads are discarded and no response is emitted after reset release. The first grant after release follows `rr`=0.

## Test plan
- Reset values: assert i_sys_resetn=0 mid-burst → all outputs 0 immediately (async). After release with both valid, req0 is granted first.
- Single client: req0 write addr 0x10 data 0xA5A5_0001, then read 0x10 → exactly one m_rsp0_valid, 3 cycles after the read handshake, data 0xA5A5_0001, m_rsp1_valid never asserted.
- Contention: both clients read continuously for 8 cycles (req0 addrs 0..7, req1 addrs 0x80..0x87) → grants alternate starting with 0. Responses are routed to the correct id in order, each with +3-cycle latency. o_conflict_cnt=8.
- Write-then-read ordering: req1 writes 0x20←0x1234 while req0 reads 0x20 in the next granted slot → req0 reads 0x1234.
- Back-to-back reads with idle gaps: issue reads at cycles 0,1,4 → m_rsp0_valid pulses at cycles 3,4,7 only. The data holds between pulses.
- Counter saturation, with WD_CNT=4: 20 contention cycles → o_conflict_cnt=15 and stays there.
